// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core back end: commit record, commit FSM
// states and exception cause codes.
package ooo_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int PC_WIDTH      = 32;
  localparam int ROB_TAG_WIDTH = 5;
  localparam int CAUSE_WIDTH   = 4;

  localparam logic [CAUSE_WIDTH-1:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [CAUSE_WIDTH-1:0] EXC_INSTR_ACCESS     = 4'd1;
  localparam logic [CAUSE_WIDTH-1:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [CAUSE_WIDTH-1:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [CAUSE_WIDTH-1:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [CAUSE_WIDTH-1:0] EXC_LOAD_ACCESS      = 4'd5;
  localparam logic [CAUSE_WIDTH-1:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [CAUSE_WIDTH-1:0] EXC_STORE_ACCESS     = 4'd7;
  localparam logic [CAUSE_WIDTH-1:0] EXC_ECALL            = 4'd8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } commit_state_e;

  typedef struct packed {
    logic                     valid;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
    logic [PC_WIDTH-1:0]      pc;
    logic [4:0]               rd_addr;
    logic                     rd_write_en;
    logic [DATA_WIDTH-1:0]    result;
    logic                     exception;
    logic [CAUSE_WIDTH-1:0]   exc_cause;
    logic                     mispredict;
    logic [PC_WIDTH-1:0]      redirect_pc;
  } ooo_commit_t;

  // x0 is hard-wired zero, so a write to it is never architecturally visible.
  function automatic logic commit_writes_rf(input ooo_commit_t c);
    return c.rd_write_en && (c.rd_addr != 5'd0) && !c.exception;
  endfunction

endpackage

// File: rtl/commit_stage_if.sv
// Bundle of the commit stage's retire-side and writeback/redirect signals.
interface commit_stage_if;
  import ooo_pkg::*;

  ooo_commit_t           commit;
  logic                  commit_ready;
  logic [PC_WIDTH-1:0]   trap_vector;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  flush;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  exc_valid;
  logic [PC_WIDTH-1:0]   exc_pc;
  logic [3:0]            exc_cause;
  logic [63:0]           instret;

  modport master (
    output commit, trap_vector,
    input  commit_ready, rf_we, rf_waddr, rf_wdata, flush, redirect_valid,
           redirect_pc, exc_valid, exc_pc, exc_cause, instret
  );

  modport slave (
    input  commit, trap_vector,
    output commit_ready, rf_we, rf_waddr, rf_wdata, flush, redirect_valid,
           redirect_pc, exc_valid, exc_pc, exc_cause, instret
  );

endinterface

// File: rtl/commit_stage.sv
// In-order retirement: architectural register writeback, instret counting and
// a one-cycle flush/redirect followed by a fixed ready-low drain window.
//
// state    | meaning
// ST_RUN   | accepting one commit per cycle
// ST_FLUSH | one cycle: flush, redirect and (for traps) exception record
// ST_DRAIN | DRAIN_CYCLES cycles of recovery, commits ignored
module commit_stage #(
  parameter int DATA_WIDTH   = ooo_pkg::DATA_WIDTH,
  parameter int PC_WIDTH     = ooo_pkg::PC_WIDTH,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  ooo_pkg::ooo_commit_t   commit_i,
  output logic                   commit_ready_o,
  input  logic [PC_WIDTH-1:0]    trap_vector_i,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [DATA_WIDTH-1:0]  rf_wdata_o,
  output logic                   flush_o,
  output logic                   redirect_valid_o,
  output logic [PC_WIDTH-1:0]    redirect_pc_o,
  output logic                   exc_valid_o,
  output logic [PC_WIDTH-1:0]    exc_pc_o,
  output logic [3:0]             exc_cause_o,
  output logic [63:0]            instret_o
);
  import ooo_pkg::*;

  localparam logic [3:0] DRAIN_CNT_INIT = 4'(DRAIN_CYCLES - 1);

  commit_state_e r_state, w_state_nxt;
  logic [3:0]    r_drain_cnt, w_drain_cnt_nxt;

  logic w_accept;
  logic w_go_flush;
  logic w_retire;
  logic w_unused;

  assign w_unused = ^commit_i.rob_tag;

  // Held low during reset even though the state register already reads RUN.
  assign commit_ready_o = rst_ni && (r_state == ST_RUN);
  assign w_accept       = commit_i.valid && commit_ready_o;
  assign w_go_flush     = w_accept && (commit_i.exception || commit_i.mispredict);
  assign w_retire       = w_accept && !commit_i.exception;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_go_flush) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_state_nxt     = ST_DRAIN;
        w_drain_cnt_nxt = DRAIN_CNT_INIT;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == 4'd0) w_state_nxt = ST_RUN;
        else                     w_drain_cnt_nxt = r_drain_cnt - 4'd1;
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_drain_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= 5'd0;
      rf_wdata_o <= '0;
      instret_o  <= 64'd0;
    end else begin
      rf_we_o <= w_accept && commit_writes_rf(commit_i);
      if (w_accept && commit_writes_rf(commit_i)) begin
        rf_waddr_o <= commit_i.rd_addr;
        rf_wdata_o <= commit_i.result;
      end
      if (w_retire) instret_o <= instret_o + 64'd1;
    end
  end

  // Pulses are registered at accept so they line up exactly with ST_FLUSH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      exc_valid_o      <= 1'b0;
      exc_pc_o         <= '0;
      exc_cause_o      <= 4'd0;
    end else begin
      flush_o          <= w_go_flush;
      redirect_valid_o <= w_go_flush;
      exc_valid_o      <= w_go_flush && commit_i.exception;
      if (w_go_flush) begin
        redirect_pc_o <= commit_i.exception ? trap_vector_i : commit_i.redirect_pc;
      end
      if (w_go_flush && commit_i.exception) begin
        exc_pc_o    <= commit_i.pc;
        exc_cause_o <= commit_i.exc_cause;
      end
    end
  end

endmodule

// File: tb/tb_commit_stage.sv
// Directed and randomized checks of commit_stage against a cycle-level model.
module tb_commit_stage;
  import ooo_pkg::*;

  localparam int DRAIN = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  commit_stage_if cif ();

  commit_stage #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .commit_i         (cif.commit),
    .commit_ready_o   (cif.commit_ready),
    .trap_vector_i    (cif.trap_vector),
    .rf_we_o          (cif.rf_we),
    .rf_waddr_o       (cif.rf_waddr),
    .rf_wdata_o       (cif.rf_wdata),
    .flush_o          (cif.flush),
    .redirect_valid_o (cif.redirect_valid),
    .redirect_pc_o    (cif.redirect_pc),
    .exc_valid_o      (cif.exc_valid),
    .exc_pc_o         (cif.exc_pc),
    .exc_cause_o      (cif.exc_cause),
    .instret_o        (cif.instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: cycles of ready-low remaining, counters and held values
  int          m_blocked;
  logic [63:0] m_instret;
  logic        e_we, e_flush, e_exc;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_rpc, e_epc;
  logic [3:0]  e_cause;
  int          we_pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ooo_commit_t mk(input logic v, input logic [4:0] rd, input logic we,
                                     input logic [31:0] res, input logic exc,
                                     input logic [3:0] cause, input logic mp,
                                     input logic [31:0] rpc, input logic [31:0] pc);
    ooo_commit_t c;
    c = '0;
    c.valid = v; c.rd_addr = rd; c.rd_write_en = we; c.result = res;
    c.exception = exc; c.exc_cause = cause; c.mispredict = mp;
    c.redirect_pc = rpc; c.pc = pc; c.rob_tag = 5'($urandom);
    return c;
  endfunction

  task automatic model_reset();
    m_blocked = 0; m_instret = 0;
    e_we = 0; e_flush = 0; e_exc = 0;
    e_waddr = 0; e_wdata = 0; e_rpc = 0; e_epc = 0; e_cause = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_ready"},   cif.commit_ready, (m_blocked == 0));
    chk({ph, "_rf_we"},   cif.rf_we, e_we);
    if (e_we) begin
      chk({ph, "_waddr"}, cif.rf_waddr, e_waddr);
      chk({ph, "_wdata"}, cif.rf_wdata, e_wdata);
    end
    chk({ph, "_flush"},   cif.flush, e_flush);
    chk({ph, "_rvalid"},  cif.redirect_valid, e_flush);
    chk({ph, "_rpc"},     cif.redirect_pc, e_rpc);
    chk({ph, "_exc_v"},   cif.exc_valid, e_exc);
    chk({ph, "_exc_pc"},  cif.exc_pc, e_epc);
    chk({ph, "_cause"},   cif.exc_cause, e_cause);
    chk({ph, "_instret"}, cif.instret, m_instret);
  endtask

  task automatic cycle(input string ph, input ooo_commit_t c, input logic [31:0] tv);
    logic acc;
    cif.commit = c;
    cif.trap_vector = tv;
    acc = c.valid && (m_blocked == 0);
    @(posedge clk);
    #1;
    e_we = 0; e_flush = 0; e_exc = 0;
    if (m_blocked > 0) m_blocked--;
    if (acc) begin
      if (c.exception) begin
        e_flush = 1; e_exc = 1;
        e_rpc = tv; e_epc = c.pc; e_cause = c.exc_cause;
        m_blocked = 1 + DRAIN;
      end else begin
        m_instret++;
        if (c.rd_write_en && c.rd_addr != 0) begin
          e_we = 1; e_waddr = c.rd_addr; e_wdata = c.result;
        end
        if (c.mispredict) begin
          e_flush = 1; e_rpc = c.redirect_pc;
          m_blocked = 1 + DRAIN;
        end
      end
    end
    if (e_we) we_pulses++;
    check_outputs(ph);
  endtask

  task automatic check_reset_values(input string ph);
    chk({ph, "_ready"},   cif.commit_ready, 0);
    chk({ph, "_rf_we"},   cif.rf_we, 0);
    chk({ph, "_waddr"},   cif.rf_waddr, 0);
    chk({ph, "_wdata"},   cif.rf_wdata, 0);
    chk({ph, "_flush"},   cif.flush, 0);
    chk({ph, "_rvalid"},  cif.redirect_valid, 0);
    chk({ph, "_rpc"},     cif.redirect_pc, 0);
    chk({ph, "_exc_v"},   cif.exc_valid, 0);
    chk({ph, "_exc_pc"},  cif.exc_pc, 0);
    chk({ph, "_cause"},   cif.exc_cause, 0);
    chk({ph, "_instret"}, cif.instret, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ooo_commit_t idle, c;
    n_tests = 0; n_fail = 0; we_pulses = 0;
    idle = '0;
    cif.commit = idle;
    cif.trap_vector = 32'h0;
    rst_n = 1'b0;
    model_reset();

    // reset state, then release
    #22;
    check_reset_values("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel_ready", cif.commit_ready, 1);

    // basic write, then x0 write suppression
    cycle("wr5", mk(1, 5'd5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 32'h10), 32'h0);
    chk("wr5_instret_is_1", cif.instret, 1);
    cycle("x0", mk(1, 5'd0, 1, 32'h12345678, 0, 0, 0, 0, 32'h14), 32'h0);
    cycle("idle", idle, 32'h0);

    // mispredict with register write and drain window
    cycle("mp", mk(1, 5'd7, 1, 32'hCAFE0001, 0, 0, 1, 32'h100, 32'h18), 32'h0);
    chk("mp_flush_rpc", cif.redirect_pc, 32'h100);
    for (int i = 0; i < 4; i++)
      cycle("mp_drain", mk(1, 5'd9, 1, $urandom, 0, 0, 0, 0, 32'h1C), 32'h0);

    // exception beats mispredict: trap vector, no write, no instret
    cycle("exc", mk(1, 5'd3, 1, 32'h55AA55AA, 1, EXC_ILLEGAL_INSTR, 1, 32'h200, 32'h40), 32'h80);
    chk("exc_rpc_trap", cif.redirect_pc, 32'h80);
    for (int i = 0; i < 4; i++) cycle("exc_drain", idle, 32'h0);

    // reset asserted in the middle of DRAIN
    cycle("mp2", mk(1, 5'd2, 1, 32'h1, 0, 0, 1, 32'h300, 32'h50), 32'h0);
    cycle("mp2_fl", idle, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_values("drain_rst");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("drain_rel_ready", cif.commit_ready, 1);
    chk("drain_rel_instret", cif.instret, 0);

    // ten back-to-back commits
    we_pulses = 0;
    for (int i = 0; i < 10; i++)
      cycle("b2b", mk(1, 5'(i + 1), 1, $urandom, 0, 0, 0, 0, 32'(i * 4)), 32'h0);
    chk("b2b_instret", cif.instret, 10);
    chk("b2b_pulses", 64'(we_pulses), 10);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      c = '0;
      c.valid       = ($urandom_range(0, 3) != 0);
      c.rob_tag     = 5'($urandom);
      c.pc          = $urandom;
      c.rd_addr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      c.rd_write_en = ($urandom_range(0, 4) != 0);
      c.result      = $urandom;
      c.exception   = ($urandom_range(0, 9) == 0);
      c.exc_cause   = 4'($urandom);
      c.mispredict  = ($urandom_range(0, 7) == 0);
      c.redirect_pc = $urandom;
      cycle("rnd", c, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
